weight_mixer: RTL and testbench

- Consumer end of the 2-bit harmonic weight interface produced by the weight-control block (0 = off, 1 = half, 2 = full).
- Scales a signed audio sample stream by the gain that the weight selects.
- Ramps gain one step per accepted sample, so weight changes do not click.
- Sits between the note/harmonic sample generator and the final sum/codec path.

---
 rtl/weight_mixer_pkg.sv | 24 ++
 rtl/weight_mixer_if.sv | 23 ++
 rtl/weight_mixer_gain_ramp.sv | 94 +++++++++
 rtl/weight_mixer.sv | 53 +++++
 tb/tb_weight_mixer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_mixer_pkg.sv
// Shared constants and types for the harmonic weight mixer: weight codes,
// gain constants derived from the gain width, and the ramp FSM state type.
package weight_mixer_pkg;

    localparam logic [1:0] W_OFF  = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_FULL = 2'd2;

    typedef enum logic [1:0] {
        SETTLED   = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    // Gain is unsigned Q1.(gain_w-1): full scale 1.0 sits at the MSB.
    function automatic int gain_full(input int gain_w);
        return 1 << (gain_w - 1);
    endfunction

    function automatic int gain_half(input int gain_w);
        return 1 << (gain_w - 2);
    endfunction

endpackage

// File: rtl/weight_mixer_if.sv
// Sample stream between the harmonic generator (master) and the mixer (slave).
interface weight_mixer_if #(
    parameter int SAMPLE_W = 16
);
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_in_valid;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       sample_out_valid;

    modport master (
        output sample_in,
        output sample_in_valid,
        input  sample_out,
        input  sample_out_valid
    );

    modport slave (
        input  sample_in,
        input  sample_in_valid,
        output sample_out,
        output sample_out_valid
    );
endinterface

// File: rtl/weight_mixer_gain_ramp.sv
// Gain ramp: maps weight to a target gain and walks the gain register toward it,
// one step per accepted sample. WEIGHT_MIXER_RAMP_EN selects stepped ramps; otherwise gain jumps.
//
// state     | meaning
// ----------+---------------------------------------------
// SETTLED   | gain equals target, gain holds
// RAMP_UP   | gain below target, rises on each accepted sample
// RAMP_DOWN | gain above target, falls on each accepted sample
module gain_ramp
    import weight_mixer_pkg::*;
#(
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        weight,
    input  logic              advance,
    output logic [GAIN_W-1:0] gain,
    output logic              ramping
);

    localparam logic [GAIN_W-1:0] GAIN_F = GAIN_W'(gain_full(GAIN_W));
    localparam logic [GAIN_W-1:0] GAIN_H = GAIN_W'(gain_half(GAIN_W));

    ramp_state_t       state, state_nxt;
    logic [GAIN_W-1:0] target;
    logic [GAIN_W-1:0] gain_nxt;

    always_comb begin
        target = GAIN_F;
        case (weight)
            W_OFF:   target = '0;
            W_HALF:  target = GAIN_H;
            W_FULL:  target = GAIN_F;
            default: target = GAIN_F;
        endcase
    end

    always_comb begin
        state_nxt = SETTLED;
        if (gain < target) begin
            state_nxt = RAMP_UP;
        end else if (gain > target) begin
            state_nxt = RAMP_DOWN;
        end
    end

`ifdef WEIGHT_MIXER_RAMP_EN
    localparam logic [GAIN_W:0] STEP = (GAIN_W+1)'(RAMP_STEP);

    // One extra bit keeps gain+step and target+step from wrapping.
    logic [GAIN_W:0] up_sum;
    logic [GAIN_W:0] down_floor;

    assign up_sum     = {1'b0, gain} + STEP;
    assign down_floor = {1'b0, target} + STEP;

    always_comb begin
        gain_nxt = gain;
        if (advance) begin
            case (state)
                RAMP_UP:   gain_nxt = (up_sum > {1'b0, target}) ? target : up_sum[GAIN_W-1:0];
                RAMP_DOWN: gain_nxt = ({1'b0, gain} < down_floor) ? target
                                                                 : gain - STEP[GAIN_W-1:0];
                default:   gain_nxt = gain;
            endcase
        end
    end
`else
    logic unused_ramp_step;
    assign unused_ramp_step = (RAMP_STEP != 0);

    always_comb begin
        gain_nxt = gain;
        if (advance && (state != SETTLED)) begin
            gain_nxt = target;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SETTLED;
            gain  <= '0;
        end else begin
            state <= state_nxt;
            gain  <= gain_nxt;
        end
    end

    assign ramping = (state != SETTLED);

endmodule

// File: rtl/weight_mixer.sv
// Harmonic weight mixer: scales the sample stream by the ramped gain with one cycle
// of latency. Build with WEIGHT_MIXER_RAMP_EN for stepped gain ramps.
module weight_mixer
    import weight_mixer_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        weight,
    weight_mixer_if.slave     bus,
    output logic [GAIN_W-1:0] gain,
    output logic              ramping
);

    logic signed [SAMPLE_W+GAIN_W:0] prod;
    logic signed [SAMPLE_W+GAIN_W:0] scaled;
    logic                            unused_scaled_msbs;

    gain_ramp #(
        .GAIN_W    (GAIN_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_gain_ramp (
        .clk     (clk),
        .reset   (reset),
        .weight  (weight),
        .advance (bus.sample_in_valid),
        .gain    (gain),
        .ramping (ramping)
    );

    // The multiplier sees the gain before this sample's ramp step lands.
    assign prod   = bus.sample_in * $signed({1'b0, gain});
    assign scaled = prod >>> (GAIN_W - 1);

    // gain never exceeds 1.0, so the product always fits back in SAMPLE_W.
    assign unused_scaled_msbs = ^scaled[SAMPLE_W+GAIN_W:SAMPLE_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.sample_out       <= '0;
            bus.sample_out_valid <= 1'b0;
        end else begin
            bus.sample_out_valid <= bus.sample_in_valid;
            if (bus.sample_in_valid) begin
                bus.sample_out <= scaled[SAMPLE_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_weight_mixer.sv
// Self-checking bench for weight_mixer: constant vector table, directed corner
// sequences and a randomized run against a behavioural gain/sample model.
module tb_weight_mixer;

    localparam int SW = 16;
    localparam int GW = 8;
    localparam int RS = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        weight = 2'd0;
    logic [GW-1:0]     gain;
    logic              ramping;

    weight_mixer_if #(.SAMPLE_W(SW)) bus ();

    weight_mixer #(
        .SAMPLE_W  (SW),
        .GAIN_W    (GW),
        .RAMP_STEP (RS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .weight  (weight),
        .bus     (bus),
        .gain    (gain),
        .ramping (ramping)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] w;
        int         d;
        logic       ov;
        int         out;
        int         g;
        logic       r;
    } vec_t;

    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    int   m_gain = 0;
    int   m_out  = 0;
    logic m_ov   = 1'b0;
    logic m_ramp = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tgt_of(input logic [1:0] w);
        case (w)
            2'd0:    return 0;
            2'd1:    return 64;
            default: return 128;
        endcase
    endfunction

    // Spec-level model: out = floor(d*gain/128) with the pre-update gain; gain moves
    // toward the weight's target on accepted samples only.
    task automatic model_edge(input logic v, input logic [1:0] w, input int d);
        int t;
        t = tgt_of(w);
        m_ramp = (m_gain != t);
        m_ov = v;
        if (v) begin
            m_out = (d * m_gain) >>> 7;
`ifdef WEIGHT_MIXER_RAMP_EN
            if (m_gain < t)      m_gain = (m_gain + RS > t) ? t : m_gain + RS;
            else if (m_gain > t) m_gain = (m_gain - RS < t) ? t : m_gain - RS;
`else
            m_gain = t;
`endif
        end
    endtask

    task automatic apply(input logic v, input logic [1:0] w, input int d);
        bus.sample_in_valid = v;
        weight = w;
        bus.sample_in = SW'(d);
        @(posedge clk);
        model_edge(v, w, d);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".gain"}, int'(gain), m_gain);
        check({tag, ".out"}, int'(bus.sample_out), m_out);
        check({tag, ".ovalid"}, int'(bus.sample_out_valid), int'(m_ov));
        check({tag, ".ramping"}, int'(ramping), int'(m_ramp));
    endtask

    task automatic run(input logic v, input logic [1:0] w, input int d, input string tag);
        apply(v, w, d);
        check_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.sample_in_valid = 1'b1;
        bus.sample_in = 16'sd1234;
        @(posedge clk);
        #1;
        check("rst.ramping", int'(ramping), 0);
        check("rst.gain", int'(gain), 0);
        check("rst.out", int'(bus.sample_out), 0);
        check("rst.ovalid", int'(bus.sample_out_valid), 0);
        m_gain = 0; m_out = 0; m_ov = 1'b0; m_ramp = 1'b0;
        reset = 1'b1;
        bus.sample_in_valid = 1'b0;
    endtask

    task automatic add(input logic v, input logic [1:0] w, input int d,
                       input logic ov, input int out, input int g, input logic r);
        vec_t e;
        e.v = v; e.w = w; e.d = d; e.ov = ov; e.out = out; e.g = g; e.r = r;
        tbl.push_back(e);
    endtask

    initial begin
        bus.sample_in = '0;
        bus.sample_in_valid = 1'b0;

        // Vector table: idle-at-zero, ramp up to full, ramp down to half.
        for (int i = 0; i < 5; i++) add(1, 0, 1000, 1, 0, 0, 0);
`ifdef WEIGHT_MIXER_RAMP_EN
        add(0, 2, 0,     0, 0,    0,   1);
        add(1, 2, 1000,  1, 0,    16,  1);
        add(1, 2, 1000,  1, 125,  32,  1);
        add(1, 2, 1000,  1, 250,  48,  1);
        add(1, 2, 1000,  1, 375,  64,  1);
        add(1, 2, 1000,  1, 500,  80,  1);
        add(1, 2, 1000,  1, 625,  96,  1);
        add(1, 2, 1000,  1, 750,  112, 1);
        add(1, 2, 1000,  1, 875,  128, 1);
        add(1, 2, 1000,  1, 1000, 128, 0);
        add(1, 2, 1000,  1, 1000, 128, 0);
        add(0, 1, 0,     0, 1000, 128, 1);
        add(1, 1, -1000, 1, -1000, 112, 1);
        add(1, 1, -1000, 1, -875, 96,  1);
        add(1, 1, -1000, 1, -750, 80,  1);
        add(1, 1, -1000, 1, -625, 64,  1);
        add(1, 1, -1000, 1, -500, 64,  0);
        add(1, 1, -1000, 1, -500, 64,  0);
`else
        add(0, 2, 0,     0, 0,    0,   1);
        add(1, 2, 1000,  1, 0,    128, 1);
        add(1, 2, 1000,  1, 1000, 128, 0);
        add(1, 2, 1000,  1, 1000, 128, 0);
        add(0, 1, 0,     0, 1000, 128, 1);
        add(1, 1, -1000, 1, -1000, 64, 1);
        add(1, 1, -1000, 1, -500, 64,  0);
        add(1, 1, -1000, 1, -500, 64,  0);
`endif

        #3;
        do_reset();
        apply(0, 0, 0);
        check("post_rst.ramping", int'(ramping), 0);

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].w, tbl[i].d);
            check($sformatf("tbl%0d.out", i), int'(bus.sample_out), tbl[i].out);
            check($sformatf("tbl%0d.ovalid", i), int'(bus.sample_out_valid), int'(tbl[i].ov));
            check($sformatf("tbl%0d.gain", i), int'(gain), tbl[i].g);
            check($sformatf("tbl%0d.ramping", i), int'(ramping), int'(tbl[i].r));
        end

        // Valid gaps mid-ramp: everything holds, then the ramp resumes.
        run(0, 2, 0, "gap.set");
        run(1, 2, 300, "gap.pre0");
        run(1, 2, 300, "gap.pre1");
        for (int i = 0; i < 5; i++) run(0, 2, 7, "gap.idle");
        run(1, 2, -300, "gap.post0");
        run(1, 2, -300, "gap.post1");

        // Retarget mid-ramp, then async reset mid-ramp.
        do_reset();
        run(0, 2, 0, "rt.set");
        for (int i = 0; i < 3; i++) run(1, 2, 500, "rt.up");
        run(0, 0, 0, "rt.zero");
        for (int i = 0; i < 4; i++) run(1, 0, 500, "rt.down");
        run(0, 2, 0, "rt.set2");
        for (int i = 0; i < 5; i++) run(1, 2, 800, "rt.up2");
        #2;
        reset = 1'b0;
        #1;
        check("arst.gain", int'(gain), 0);
        check("arst.out", int'(bus.sample_out), 0);
        check("arst.ovalid", int'(bus.sample_out_valid), 0);
        check("arst.ramping", int'(ramping), 0);
        bus.sample_in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("arst.held_gain", int'(gain), 0);
        m_gain = 0; m_out = 0; m_ov = 1'b0; m_ramp = 1'b0;
        reset = 1'b1;
        run(0, 2, 0, "rel.first");
        check("rel.ramping", int'(ramping), 1);

        // Extremes at full gain, illegal weight 3.
        for (int i = 0; i < 10; i++) run(1, 2, 0, "ext.settle");
        apply(1, 2, -32768);
        check("ext.min", int'(bus.sample_out), -32768);
        apply(1, 2, 32767);
        check("ext.max", int'(bus.sample_out), 32767);
        apply(0, 3, 0);
        check("w3.ramping", int'(ramping), 0);
        apply(1, 3, 1000);
        check("w3.out", int'(bus.sample_out), 1000);
        check("w3.gain", int'(gain), 128);

        // 0 -> 2 step from zero gain.
        run(0, 0, 0, "step.zero");
        for (int i = 0; i < 10; i++) run(1, 0, 100, "step.settle0");
        run(0, 2, 0, "step.set2");
        run(1, 2, 100, "step.first");
        run(1, 2, 100, "step.second");

        // Randomized run; weight only moves on cycles without a sample.
        begin
            logic [1:0] w;
            w = 2'd2;
            for (int i = 0; i < 400; i++) begin
                logic v;
                int   d;
                v = ($urandom_range(0, 3) != 0);
                if (!v && ($urandom_range(0, 5) == 0)) w = 2'($urandom_range(0, 3));
                d = $urandom_range(0, 65535) - 32768;
                run(v, w, d, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
